gsim_mb_encoder: RTL

Forward banded matrix-vector multiplier for the GSIM solver datapath. It consumes a 16-entry solution stream x in 16.16 two's-complement and produces b = M·x on the same style of in_en/out_valid stream. M is the GSIM symmetric 7-band Toeplitz matrix with diagonals (-1, 6, -13, 20, -13, 6, -1); entries outside the matrix are zero. It sits on the other end of the GSIM interface: it regenerates b_in-style vectors from x_out, for stimulus generation and for in-system residual checking.

---
 rtl/gsim_mb_encoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/gsim_mb_encoder.sv
// GSIM forward banded multiplier: streams x (16.16) in and emits b = M*x for the symmetric
// 7-band Toeplitz matrix (-1, 6, -13, 20, -13, 6, -1). Optional macro GSIM_MB_ROUND_EN adds b_rnd.
module gsim_mb_encoder #(
    parameter int N  = 16,
    parameter int XW = 32,
    parameter int BW = 38
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [XW-1:0] x_in,
    output logic          out_valid,
    output logic [BW-1:0] b_out,
`ifdef GSIM_MB_ROUND_EN
    output logic [15:0]   b_rnd,
`endif
    output logic          frame_done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t        state;
    logic [XW-1:0] w [7];
    logic [XW-1:0] nw [7];
    logic [BW-1:0] e [7];
    logic [CW-1:0] cnt;
    logic [1:0]    fcnt;
    logic          flushing;
    logic          accept;
    logic          emit;
    logic [BW-1:0] sum;

    assign flushing = (state == FLUSH);
    assign accept   = in_en && !flushing;
    assign emit     = flushing || (accept && (cnt >= CW'(3)));

    // Results are taken from the window as it will look after this edge's shift,
    // so the registered output lines up one cycle after the sample that completes it.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            nw[i] = w[i+1];
        end
        nw[6] = flushing ? '0 : x_in;
        for (int i = 0; i < 7; i++) begin
            e[i] = {{(BW-XW){nw[i][XW-1]}}, nw[i]};
        end
    end

    assign sum = ((e[1] << 2) + (e[1] << 1) + (e[5] << 2) + (e[5] << 1))
               + ((e[3] << 4) + (e[3] << 2))
               - ((e[2] << 3) + (e[2] << 2) + e[2])
               - ((e[4] << 3) + (e[4] << 2) + e[4])
               - e[0] - e[6];

`ifdef GSIM_MB_ROUND_EN
    logic signed [BW:0] rsum;
    logic signed [BW:0] rsh;
    logic [15:0]        rnd;

    // Round half-up by adding 0.5 and flooring with an arithmetic shift, then clamp to 16 bits.
    always_comb begin
        rsum = $signed({sum[BW-1], sum}) + $signed((BW+1)'(32'h8000));
        rsh  = rsum >>> 16;
        if ((&rsh[BW:15]) || !(|rsh[BW:15])) begin
            rnd = rsh[15:0];
        end else begin
            rnd = rsh[BW] ? 16'h8000 : 16'h7FFF;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fcnt       <= '0;
            out_valid  <= 1'b0;
            b_out      <= '0;
            frame_done <= 1'b0;
`ifdef GSIM_MB_ROUND_EN
            b_rnd      <= '0;
`endif
            for (int i = 0; i < 7; i++) begin
                w[i] <= '0;
            end
        end else begin
            out_valid  <= emit;
            frame_done <= flushing && (fcnt == 2'd2);
            if (emit) begin
                b_out <= sum;
`ifdef GSIM_MB_ROUND_EN
                b_rnd <= rnd;
`endif
            end
            case (state)
                IDLE: begin
                    if (in_en) begin
                        for (int i = 0; i < 7; i++) begin
                            w[i] <= nw[i];
                        end
                        cnt   <= CW'(1);
                        state <= FILL;
                    end
                end
                FILL, RUN: begin
                    if (in_en) begin
                        for (int i = 0; i < 7; i++) begin
                            w[i] <= nw[i];
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) begin
                            fcnt  <= '0;
                            state <= FLUSH;
                        end else if (cnt >= CW'(3)) begin
                            state <= RUN;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + 2'd1;
                    // The last flush cycle leaves a zero window ready for the next frame's x[-3..-1].
                    if (fcnt == 2'd2) begin
                        for (int i = 0; i < 7; i++) begin
                            w[i] <= '0;
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        for (int i = 0; i < 7; i++) begin
                            w[i] <= nw[i];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
